fetch_ctrl: RTL and testbench

- Sequences instruction fetch against a variable-latency instruction memory with a req/ack handshake.
- Owns the fetch PC, presents one instruction per slot to the ID stage, and honours ID back-pressure (id_stall).
- Honours branch/jump redirects, including redirects that arrive while a memory request is in flight.
- Replaces the single-cycle PC/IM pairing in the IF stage once instruction memory becomes multi-cycle.

---
 rtl/fetch_ctrl_if.sv | 22 ++
 rtl/fetch_ctrl.sv | 82 ++++++++
 tb/tb_fetch_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: IF-stage bundle, instruction-memory req/ack plus the ID-side slot and redirect.
interface fetch_ctrl_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid_IF;
  logic [31:0] Instr_IF;
  logic [31:0] pc_IF;
  logic [31:0] pc4_IF;
  modport master (
    input  redirect, redirect_pc, id_stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, valid_IF, Instr_IF, pc_IF, pc4_IF
  );
  modport slave (
    output redirect, redirect_pc, id_stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, valid_IF, Instr_IF, pc_IF, pc4_IF
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer over a variable-latency req/ack instruction memory.
// Defining FETCH_TRACE_EN adds a simulation-only consumption/redirect trace.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;
  state_t      state;
  logic [31:0] fetch_pc, skid_instr, skid_pc, tgt;
  logic        ack, free, to_discard;
  assign tgt        = bus.redirect_pc & ~32'h3;
  assign ack        = bus.imem_ack & bus.imem_req;
  assign free       = !bus.valid_IF || !bus.id_stall;
  assign to_discard = state == DISCARD || (state == WAIT && !ack);
  assign bus.pc4_IF = bus.pc_IF + 32'd4;
  // an outstanding request must see its ack before a new address goes out
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      skid_instr    <= '0;
      skid_pc       <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
      bus.valid_IF  <= 1'b0;
      bus.Instr_IF  <= '0;
      bus.pc_IF     <= '0;
    end else if (bus.redirect) begin
      fetch_pc      <= tgt;
      bus.valid_IF  <= 1'b0;
      bus.imem_req  <= 1'b1;
      bus.imem_addr <= to_discard ? bus.imem_addr : tgt;
      state         <= to_discard ? DISCARD : WAIT;
    end else begin
      if (!bus.id_stall) bus.valid_IF <= 1'b0;
      case (state)
        IDLE: begin
          state         <= WAIT;
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= fetch_pc;
        end
        WAIT:
          if (ack && free) begin
            bus.Instr_IF  <= bus.imem_rdata;
            bus.pc_IF     <= fetch_pc;
            bus.valid_IF  <= 1'b1;
            fetch_pc      <= fetch_pc + 32'd4;
            bus.imem_addr <= fetch_pc + 32'd4;
          end else if (ack) begin
            skid_instr   <= bus.imem_rdata;
            skid_pc      <= fetch_pc;
            fetch_pc     <= fetch_pc + 32'd4;
            bus.imem_req <= 1'b0;
            state        <= HOLD;
          end
        HOLD:
          if (!bus.id_stall) begin
            bus.Instr_IF  <= skid_instr;
            bus.pc_IF     <= skid_pc;
            bus.valid_IF  <= 1'b1;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= fetch_pc;
            state         <= WAIT;
          end
        default:
          if (ack) begin
            bus.imem_addr <= fetch_pc;
            state         <= WAIT;
          end
      endcase
    end
`ifdef FETCH_TRACE_EN
  always @(posedge clk)
    if (rst) begin
      if (bus.valid_IF && !bus.id_stall) $display("PC: %h \"%h\"", bus.pc_IF, bus.Instr_IF);
      if (bus.redirect) $display("REDIRECT -> %h", tgt);
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run checked against a program-order fetch model.
module tb_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b0, force_ack = 1'b0, ack_r = 1'b0;
  int   lat = 0, cnt = 0, checks = 0, failures = 0;
  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  // memory: lat==0 acks in the request cycle, otherwise on the (lat+1)th cycle of a request
  assign bus.imem_ack   = force_ack | (lat == 0 ? bus.imem_req : ack_r);
  assign bus.imem_rdata = mem_word(bus.imem_addr);
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      cnt = 0;
      ack_r = 1'b0;
    end else begin
      if (ack_r) begin
        ack_r = 1'b0;
        cnt = 0;
      end
      if (bus.imem_req) begin
        cnt++;
        ack_r = cnt > lat;
      end else cnt = 0;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  task automatic reset_dut(input int l);
    rst = 1'b0; lat = l; force_ack = 1'b0;
    bus.id_stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; lat = 2; force_ack = 1'b1;
    bus.id_stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (3) begin
      @(negedge clk);
      checks++; if ({bus.valid_IF, bus.imem_req} !== 2'b00) begin failures++; $display("FAIL reset_outputs got=%b exp=00", {bus.valid_IF, bus.imem_req}); end
      checks++; if (bus.pc_IF !== 32'h0 || bus.Instr_IF !== 32'h0) begin failures++; $display("FAIL reset_slot got=%h/%h exp=0/0", bus.pc_IF, bus.Instr_IF); end
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_first_cycle_req got=%b exp=0", bus.imem_req); end
    @(negedge clk);
    force_ack = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin failures++; $display("FAIL reset_first_req got=%b/%h exp=1/00003000", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.valid_IF !== 1'b0) begin failures++; $display("FAIL reset_stale_ack got=%b exp=0", bus.valid_IF); end
  endtask

  task automatic test_zero_wait();
    reset_dut(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.valid_IF !== 1'b1 || bus.pc_IF !== 32'h3000 + 4 * i) begin failures++; $display("FAIL zero_wait_pc%0d got=%b/%h exp=1/%h", i, bus.valid_IF, bus.pc_IF, 32'h3000 + 4 * i); end
      checks++; if (bus.Instr_IF !== mem_word(bus.pc_IF) || bus.pc4_IF !== bus.pc_IF + 32'd4) begin failures++; $display("FAIL zero_wait_data%0d got=%h/%h", i, bus.Instr_IF, bus.pc4_IF); end
    end
  endtask

  task automatic test_latency2();
    int n;
    reset_dut(2);
    n = 0;
    while (bus.imem_ack !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (bus.valid_IF !== 1'b1 || bus.Instr_IF !== mem_word(32'h3000)) begin failures++; $display("FAIL lat2_first got=%b/%h exp=1/%h", bus.valid_IF, bus.Instr_IF, mem_word(32'h3000)); end
    n = 1;
    while (bus.imem_ack !== 1'b1 && n < 10) begin
      checks++; if (bus.imem_addr !== 32'h3004 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL lat2_addr_hold got=%b/%h exp=1/00003004", bus.imem_req, bus.imem_addr); end
      @(negedge clk); n++;
    end
    checks++; if (n !== 3 || bus.imem_addr !== 32'h3004) begin failures++; $display("FAIL lat2_ack_cycle got=%0d/%h exp=3/00003004", n, bus.imem_addr); end
    @(negedge clk);
    checks++; if (bus.valid_IF !== 1'b1 || bus.pc_IF !== 32'h3004 || bus.Instr_IF !== mem_word(32'h3004)) begin failures++; $display("FAIL lat2_second got=%b/%h/%h exp=1/00003004", bus.valid_IF, bus.pc_IF, bus.Instr_IF); end
  endtask

  task automatic test_back_pressure();
    reset_dut(0);
    @(negedge clk);
    bus.id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0 || bus.valid_IF !== 1'b1) begin failures++; $display("FAIL bp_hold%0d got=req%b/valid%b exp=req0/valid1", i, bus.imem_req, bus.valid_IF); end
      checks++; if (bus.pc_IF !== 32'h3000 || bus.Instr_IF !== mem_word(32'h3000)) begin failures++; $display("FAIL bp_stable%0d got=%h/%h exp=00003000", i, bus.pc_IF, bus.Instr_IF); end
    end
    bus.id_stall = 1'b0;
    @(negedge clk);
    checks++; if (bus.valid_IF !== 1'b1 || bus.pc_IF !== 32'h3004 || bus.Instr_IF !== mem_word(32'h3004)) begin failures++; $display("FAIL bp_skid got=%b/%h/%h exp=1/00003004", bus.valid_IF, bus.pc_IF, bus.Instr_IF); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3008) begin failures++; $display("FAIL bp_resume got=%b/%h exp=1/00003008", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    checks++; if (bus.pc_IF !== 32'h3008) begin failures++; $display("FAIL bp_next got=%h exp=00003008", bus.pc_IF); end
  endtask

  task automatic test_inflight_redirect();
    int n;
    reset_dut(2);
    n = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h3008) && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.imem_ack !== 1'b0 || n >= 20) begin failures++; $display("FAIL inflight_setup got=ack%b/n%0d exp=ack0", bus.imem_ack, n); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h3102;
    @(negedge clk);
    bus.redirect = 1'b0;
    n = 0;
    while (bus.imem_addr === 32'h3008 && n < 20) begin
      checks++; if (bus.valid_IF !== 1'b0 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL inflight_drop got=valid%b/req%b exp=valid0/req1", bus.valid_IF, bus.imem_req); end
      @(negedge clk); n++;
    end
    checks++; if (n !== 2 || bus.imem_addr !== 32'h3100 || bus.valid_IF !== 1'b0) begin failures++; $display("FAIL inflight_reissue got=%0d/%h/%b exp=2/00003100/0", n, bus.imem_addr, bus.valid_IF); end
    n = 0;
    while (bus.valid_IF !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.pc_IF !== 32'h3100 || bus.Instr_IF !== mem_word(32'h3100)) begin failures++; $display("FAIL inflight_target got=%h/%h exp=00003100/%h", bus.pc_IF, bus.Instr_IF, mem_word(32'h3100)); end
  endtask

  task automatic test_redirect_ack();
    reset_dut(0);
    repeat (2) @(negedge clk);
    checks++; if (bus.pc_IF !== 32'h3004 || bus.imem_addr !== 32'h3008 || bus.imem_ack !== 1'b1) begin failures++; $display("FAIL rack_setup got=%h/%h/%b", bus.pc_IF, bus.imem_addr, bus.imem_ack); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h5557;
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++; if (bus.valid_IF !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5554) begin failures++; $display("FAIL rack_drop got=%b/%b/%h exp=0/1/00005554", bus.valid_IF, bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    checks++; if (bus.valid_IF !== 1'b1 || bus.pc_IF !== 32'h5554 || bus.Instr_IF !== mem_word(32'h5554)) begin failures++; $display("FAIL rack_target got=%b/%h/%h exp=1/00005554", bus.valid_IF, bus.pc_IF, bus.Instr_IF); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    reset_dut(0);
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFA;
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffff8", bus.imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.valid_IF !== 1'b1 || bus.pc_IF !== exp_pc[i] || bus.pc4_IF !== exp_pc[i] + 32'd4) begin failures++; $display("FAIL wrap_pc%0d got=%b/%h/%h exp=1/%h", i, bus.valid_IF, bus.pc_IF, bus.pc4_IF, exp_pc[i]); end
    end
  endtask

  // model: consumed instructions follow program order from the last redirect target, each equal to mem[pc]
  task automatic test_random(input int l, input int cycles);
    logic [31:0] exp_pc, p_addr;
    logic        p_req, p_hs;
    int          consumed;
    exp_pc = 32'h3000; p_addr = '0; p_req = 1'b0; p_hs = 1'b0; consumed = 0;
    reset_dut(l);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checks++; if (bus.imem_addr[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align got=%h", bus.imem_addr); end
      if (p_req && !p_hs) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== p_addr) begin failures++; $display("FAIL rnd_req_stable got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, p_addr); end
      end
      if (bus.valid_IF) begin
        checks++; if (bus.pc4_IF !== bus.pc_IF + 32'd4) begin failures++; $display("FAIL rnd_pc4 got=%h pc=%h", bus.pc4_IF, bus.pc_IF); end
      end
      p_req = bus.imem_req; p_hs = bus.imem_req && bus.imem_ack; p_addr = bus.imem_addr;
      force_ack = !bus.imem_req && ($urandom % 3 == 0);
      bus.id_stall = ($urandom % 3 == 0);
      bus.redirect = ($urandom % 12 == 0);
      bus.redirect_pc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      if (bus.valid_IF && !bus.id_stall) begin
        checks++; if (bus.pc_IF !== exp_pc || bus.Instr_IF !== mem_word(exp_pc)) begin failures++; $display("FAIL rnd_consume got=%h/%h exp=%h/%h", bus.pc_IF, bus.Instr_IF, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (bus.redirect) exp_pc = bus.redirect_pc & ~32'h3;
    end
    @(negedge clk);
    force_ack = 1'b0; bus.redirect = 1'b0; bus.id_stall = 1'b0;
    checks++; if (consumed < cycles / 20) begin failures++; $display("FAIL rnd_progress got=%0d exp>=%0d", consumed, cycles / 20); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency2();
    test_back_pressure();
    test_inflight_redirect();
    test_redirect_ack();
    test_wrap();
    for (int r = 0; r < 4; r++) test_random(r, 600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
